mb_seq_pp_accumulator: RTL
==========================

Name: mb_seq_pp_accumulator

Overview:
- Sequential radix-4 Modified Booth multiplier core, 16x16 signed -> 32-bit product.
- Recodes multiplier b into MB digits (one_j, two_j, sign_j) and drives an internal pp_mb_generator with them.
- Consumes that generator's 17-bit partial products and accumulates DIGITS_PER_CYCLE of them per clock.
- Sits directly downstream of pp_mb_generator; also provides the recoding stage that feeds it. Valid/ready handshake on both sides.

Parameters:
DIGITS_PER_CYCLE, 1, MB digits processed per CALC cycle; legal values 1, 2, 4, 8; CALC length = 8/DIGITS_PER_CYCLE cycles.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b valid
in_ready  output  1  core can accept operands
a  input  16  multiplicand, two's complement
b  input  16  multiplier, two's complement
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  32  a*b, two's complement
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, in_ready=1, out_valid=0, product=0, busy=0, digit counter=0, accumulator=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, latch a and b, set acc=0xAAAB0000, counter=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle process digits j=counter .. counter+DIGITS_PER_CYCLE-1, then advance counter by DIGITS_PER_CYCLE. After digit 7 has been processed, go to DONE.
  - DONE: out_valid=1, product=acc, held stable while out_ready=0. On out_ready=1, go to IDLE; in_ready rises the next cycle. No same-cycle accept of a new operand pair in DONE.
- Latency: handshake at cycle T; product valid at T+1+8/DIGITS_PER_CYCLE (T+9 for the default). Throughput is one result per 8/DPC+2 cycles with out_ready tied high.
- Recoding, digit j (b[-1]=0):
  - one_j = b[2j]^b[2j-1]
  - two_j = (b[2j+1]&~b[2j]&~b[2j-1]) | (~b[2j+1]&b[2j]&b[2j-1])
  - sign_j = b[2j+1]
- Per-digit partial product pp_j (17 bits): bits 0..15 = ((a[i]&one_j)|(a[i-1]&two_j))^sign_j with a[-1]=0; bit 16 = inverted sign-extension bit.
- Per-digit accumulation: acc += (pp_j << 2j) + (sign_j << 2j), modulo 2^32.
- Correction constant: 0xAAAB0000 = -(sum over j=0..7 of 2^(16+2j)) mod 2^32. It compensates the inverted MSBs, so the final acc equals the exact signed product. No overflow is possible: |a*b| <= 2^30.
- Digit 0b111 (one=two=0, sign=1): the all-ones PP plus sign_j contributes 0. Required.
- Operands are sampled only at the IDLE handshake; changes on a and b during CALC/DONE are ignored.
- rst_n asserted mid-CALC or mid-DONE: immediate return to IDLE with reset values; the partial result is discarded and no out_valid pulse is produced.
- in_valid=1 while not in IDLE: ignored, no latch.

Optional Feature:
MB_SEQ_FLUSH_EN
- Defined: adds port flush (input, 1).
  - flush=1 in CALC or DONE returns to IDLE at the next edge, drops out_valid, and does not present a product.
  - flush=1 in IDLE has no effect.
  - flush has priority over out_ready in DONE.
- Undefined: no flush port; the FSM leaves CALC/DONE only via completion/out_ready or rst_n.

Test Plan:
- a=0x0003, b=0x0005, out_ready=1 -> product=0x0000000F, out_valid exactly at T+9 (DPC=1).
- a=0xFFFF, b=0xFFFF -> product=0x00000001; a=0x8000, b=0x8000 -> product=0x40000000.
- a=0x7FFF, b=0x8000 -> product=0xC0008000; a=0x1234, b=0x0000 -> 0x00000000.
- Backpressure: a=0x0002, b=0xFFFD, out_ready=0 for 5 cycles -> product=0xFFFFFFFA held stable with out_valid=1; in_ready=0 throughout; IDLE the cycle after out_ready=1.
- rst_n pulsed low at T+4 -> out_valid=0, in_ready=1 immediately; the next operation a=7, b=9 yields 0x0000003F.
- Sweep DIGITS_PER_CYCLE=1,2,4,8 with 10^4 random signed pairs against a reference model; latency is 9/5/3/2 cycles. With MB_SEQ_FLUSH_EN, flush at T+3 -> no out_valid, in_ready=1 at T+4.

Source files
------------

// File: rtl/mb_seq_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mb_seq_pp_accumulator
// Brief    : Sequential radix-4 Modified Booth 16x16 signed multiplier that
//            recodes b, generates 17-bit PPs and accumulates DIGITS_PER_CYCLE
//            per clock. Optional macro MB_SEQ_FLUSH_EN adds a flush input.
// Revision : 1.0 - initial release
// ============================================================================
module mb_seq_pp_accumulator #(
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
`ifdef MB_SEQ_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Cancels the 2^16 offset that each inverted sign-extension bit adds.
  localparam logic [31:0] c_acc_init = 32'hAAAB_0000;
  localparam logic [3:0]  c_dpc      = 4'(DIGITS_PER_CYCLE);

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;

  logic        w_flush;
  logic [16:0] w_bx;
  logic [31:0] w_contrib [DIGITS_PER_CYCLE];
  logic [31:0] w_acc_next;
  logic [3:0]  w_cnt_next;
  logic        w_last;

`ifdef MB_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  function automatic logic [16:0] pp_gen(input logic [15:0] m, input logic one,
                                         input logic two, input logic sign);
    logic [15:0] sel;
    sel = ({16{one}} & m) | ({16{two}} & {m[14:0], 1'b0});
    return {~((m[15] & (one | two)) ^ sign), sel ^ {16{sign}}};
  endfunction

  assign w_bx = {r_b, 1'b0};

  for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_digit
    logic [3:0]  w_j;
    logic [4:0]  w_sh;
    logic [2:0]  w_trip;
    logic        w_one;
    logic        w_two;
    logic        w_sign;
    logic [16:0] w_pp;

    assign w_j    = r_cnt + 4'(k);
    assign w_sh   = {w_j, 1'b0};
    // w_trip = {b[2j+1], b[2j], b[2j-1]}
    assign w_trip = 3'(w_bx >> w_sh);
    assign w_one  = w_trip[1] ^ w_trip[0];
    assign w_two  = (w_trip[2] & ~w_trip[1] & ~w_trip[0]) |
                    (~w_trip[2] & w_trip[1] & w_trip[0]);
    assign w_sign = w_trip[2];
    assign w_pp   = pp_gen(r_a, w_one, w_two, w_sign);
    assign w_contrib[k] = (32'(w_pp) << w_sh) + (32'(w_sign) << w_sh);
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      w_acc_next = w_acc_next + w_contrib[k];
    end
  end

  assign w_cnt_next = r_cnt + c_dpc;
  assign w_last     = (w_cnt_next == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= c_acc_init;
            r_cnt    <= '0;
            r_state  <= S_CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_flush) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
              product   <= w_acc_next;
            end
          end
        end
        S_DONE: begin
          // Leaving DONE never overlaps with a new accept; IDLE follows first.
          if (w_flush || out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
